// File: rtl/seg_editor_pkg.sv
// Shared constants and types for the 7-segment character editor.
package seg_editor_pkg;

   // All segments off (patterns are active-low)
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Default build parameters
   localparam int DEF_N_DIGITS  = 7;
   localparam int DEF_N_CHARS   = 63;
   localparam int DEF_SCAN_DIV  = 25000;
   localparam int DEF_BLINK_DIV = 12500000;

   // Edit buttons after qualification by mode
   typedef struct packed {
      logic left;
      logic right;
      logic up;
      logic down;
   } btn_t;

endpackage

// File: rtl/seg_editor_if.sv
// Control/display bundle between a front panel (master) and seg_editor (slave).
interface seg_editor_if
   import seg_editor_pkg::*;
#(
   parameter int N_DIGITS = DEF_N_DIGITS,
   parameter int N_CHARS  = DEF_N_CHARS
);
   localparam int CW = $clog2(N_CHARS);
   localparam int PW = $clog2(N_DIGITS);

   logic                     mode;
   logic                     btn_left;
   logic                     btn_right;
   logic                     btn_up;
   logic                     btn_down;
   logic                     load;
   logic [N_DIGITS*CW-1:0]   load_data;
   logic [N_DIGITS-1:0]      digit_sel;
   logic [6:0]               seg;
   logic [N_DIGITS*CW-1:0]   chars;
   logic [PW-1:0]            cursor;

   modport master (
      output mode, btn_left, btn_right, btn_up, btn_down, load, load_data,
      input  digit_sel, seg, chars, cursor
   );

   modport slave (
      input  mode, btn_left, btn_right, btn_up, btn_down, load, load_data,
      output digit_sel, seg, chars, cursor
   );

endinterface

// File: rtl/seg_glyph.sv
// Character code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Codes 0..15 are hex digits, 16 is a dash, everything else is blank.
module seg_glyph
   import seg_editor_pkg::*;
#(
   parameter int CW = 6
)(
   input  logic [CW-1:0] code,
   output logic [6:0]    pattern
);

   logic [7:0] c;
   assign c = 8'(code);

   // Pure lookup; unmapped codes fall through to blank
   always_comb begin
      pattern = SEG_BLANK;
      case (c)
         8'd0:  pattern = 7'h40;
         8'd1:  pattern = 7'h79;
         8'd2:  pattern = 7'h24;
         8'd3:  pattern = 7'h30;
         8'd4:  pattern = 7'h19;
         8'd5:  pattern = 7'h12;
         8'd6:  pattern = 7'h02;
         8'd7:  pattern = 7'h78;
         8'd8:  pattern = 7'h00;
         8'd9:  pattern = 7'h10;
         8'd10: pattern = 7'h08;
         8'd11: pattern = 7'h03;
         8'd12: pattern = 7'h46;
         8'd13: pattern = 7'h21;
         8'd14: pattern = 7'h06;
         8'd15: pattern = 7'h0E;
         8'd16: pattern = 7'h3F;
         default: pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_editor.sv
// Multiplexed 7-segment display with an in-place character editor.
// Scan runs continuously; in edit mode the cursor position blinks and
// buttons move the cursor or step the code under it.
module seg_editor
   import seg_editor_pkg::*;
#(
   parameter int N_DIGITS  = DEF_N_DIGITS,
   parameter int N_CHARS   = DEF_N_CHARS,
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int BLINK_DIV = DEF_BLINK_DIV
)(
   input  logic        clk,
   input  logic        rst,
   seg_editor_if.slave bus
);

   localparam int CW = $clog2(N_CHARS);
   localparam int PW = $clog2(N_DIGITS);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);

   localparam logic [CW-1:0]       CMAX  = CW'(N_CHARS - 1);
   localparam logic [CW-1:0]       C_ONE = CW'(1);
   localparam logic [PW-1:0]       PMAX  = PW'(N_DIGITS - 1);
   localparam logic [PW-1:0]       P_ONE = PW'(1);
   localparam logic [SW-1:0]       SMAX  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0]       S_ONE = SW'(1);
   localparam logic [BW-1:0]       BMAX  = BW'(BLINK_DIV - 1);
   localparam logic [BW-1:0]       B_ONE = BW'(1);
   localparam logic [N_DIGITS-1:0] SEL0  = N_DIGITS'(1);

   logic [N_DIGITS-1:0][CW-1:0] chars_q;
   logic [N_DIGITS-1:0][CW-1:0] load_v;
   logic [PW-1:0]               cursor_q;
   logic [PW-1:0]               scan_idx;
   logic [SW-1:0]               scan_cnt;
   logic [BW-1:0]               blink_cnt;
   logic                        blink_phase;
   logic [N_DIGITS-1:0]         digit_sel_q;
   logic [6:0]                  seg_q;
   logic [6:0]                  glyph_pat;
   btn_t                        btn;
   logic                        edit;
   logic                        inc_c;
   logic                        dec_c;

   // Buttons only count in edit mode; opposing pairs cancel
   assign btn   = bus.mode ? btn_t'({bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down}) : '0;
   assign edit  = |btn;
   assign inc_c = btn.up & ~btn.down;
   assign dec_c = btn.down & ~btn.up;

   assign load_v        = bus.load_data;
   assign bus.chars     = chars_q;
   assign bus.cursor    = cursor_q;
   assign bus.digit_sel = digit_sel_q;
   assign bus.seg       = seg_q;

   // Cursor: held at 0 outside edit mode, wraps both ways
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cursor_q <= '0;
      else if (!bus.mode)
         cursor_q <= '0;
      else if (btn.left && !btn.right)
         cursor_q <= (cursor_q == '0) ? PMAX : cursor_q - P_ONE;
      else if (btn.right && !btn.left)
         cursor_q <= (cursor_q == PMAX) ? '0 : cursor_q + P_ONE;
   end

   // Codes: load overrides editing; edits use the cursor before any move
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chars_q <= '0;
      end else begin
         for (int p = 0; p < N_DIGITS; p++) begin
            if (bus.load)
               chars_q[p] <= (load_v[p] > CMAX) ? '0 : load_v[p];
            else if (cursor_q == PW'(p) && inc_c)
               chars_q[p] <= (chars_q[p] == CMAX) ? '0 : chars_q[p] + C_ONE;
            else if (cursor_q == PW'(p) && dec_c)
               chars_q[p] <= (chars_q[p] == '0) ? CMAX : chars_q[p] - C_ONE;
         end
      end
   end

   // Scan prescaler and position index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SMAX) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == PMAX) ? '0 : scan_idx + P_ONE;
      end else begin
         scan_cnt <= scan_cnt + S_ONE;
      end
   end

   // Blink timer: idle outside edit mode, restarted by any edit so the
   // touched digit shows immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!bus.mode || edit) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BMAX) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + B_ONE;
      end
   end

   seg_glyph #(.CW(CW)) u_glyph (
      .code    (chars_q[scan_idx]),
      .pattern (glyph_pat)
   );

   // Registered display drive, cursor digit blanked in the off phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_sel_q <= '1;
         seg_q       <= SEG_BLANK;
      end else begin
         digit_sel_q <= ~(SEL0 << scan_idx);
         seg_q       <= (bus.mode && blink_phase && scan_idx == cursor_q) ? SEG_BLANK : glyph_pat;
      end
   end

endmodule

// File: tb/tb_seg_editor.sv
// Scoreboard bench for seg_editor (4 digits, 10 codes, scan 4, blink 16).
module tb_seg_editor;

   localparam int ND = 4;
   localparam int NC = 10;
   localparam int SD = 4;
   localparam int BD = 16;

   localparam int K_CHARS = 0;
   localparam int K_CUR   = 1;
   localparam int K_DSEL  = 2;
   localparam int K_SEG   = 3;

   localparam logic [3:0] B_L = 4'b1000;
   localparam logic [3:0] B_R = 4'b0100;
   localparam logic [3:0] B_U = 4'b0010;
   localparam logic [3:0] B_D = 4'b0001;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg_editor_if #(.N_DIGITS(ND), .N_CHARS(NC)) bus ();

   seg_editor #(
      .N_DIGITS  (ND),
      .N_CHARS   (NC),
      .SCAN_DIV  (SD),
      .BLINK_DIV (BD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t        sbq[$];
   int          rd     = 0;
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          base   = 0;
   logic [31:0] mon_act;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int kind);
      case (kind)
         K_CHARS: return 32'(bus.chars);
         K_CUR:   return 32'(bus.cursor);
         K_DSEL:  return 32'(bus.digit_sel);
         default: return 32'(bus.seg);
      endcase
   endfunction

   // Monitor: compare every expectation that falls due this cycle
   always @(negedge clk) begin
      while (rd < sbq.size() && sbq[rd].cyc <= cyc) begin
         n_chk++;
         mon_act = actual(sbq[rd].kind);
         if (sbq[rd].cyc < cyc)
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sbq[rd].nm, sbq[rd].cyc, cyc);
         else if (mon_act === sbq[rd].val)
            n_pass++;
         else
            $display("FAIL %s @cyc %0d: got %h, expected %h", sbq[rd].nm, cyc, mon_act, sbq[rd].val);
         rd++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int dly, input int kind, input logic [31:0] v, input string nm);
      sbq.push_back('{cyc + dly, kind, v, nm});
   endtask

   task automatic pulse(input logic [3:0] b, input logic ld, input logic [15:0] d);
      {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = b;
      bus.load      = ld;
      bus.load_data = d;
      tick();
      {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = 4'b0;
      bus.load      = 1'b0;
   endtask

   function automatic int idx_at(input int c);
      return ((c - base - 1) / SD) % ND;
   endfunction

   function automatic logic [31:0] dsel(input int i);
      logic [3:0] one;
      logic [3:0] v;
      one = 4'b0001;
      v   = ~(one << i);
      return {28'b0, v};
   endfunction

   initial begin
      int p;
      int c;
      int v;
      int guard;
      int n_left;

      bus.mode      = 1'b0;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.btn_up    = 1'b0;
      bus.btn_down  = 1'b0;
      bus.load      = 1'b0;
      bus.load_data = '0;

      // Reset state
      expect_at(1, K_CHARS, 32'h0,  "rst_chars");
      expect_at(1, K_CUR,   32'h0,  "rst_cursor");
      expect_at(1, K_DSEL,  32'hF,  "rst_dsel");
      expect_at(1, K_SEG,   32'h7F, "rst_seg");
      expect_at(2, K_DSEL,  32'hF,  "rst_dsel2");
      tick();
      tick();
      rst  = 1'b0;
      base = cyc;

      // Display-only scan of all-zero codes
      for (int k = 1; k <= 16; k++) begin
         expect_at(k, K_DSEL, dsel(idx_at(cyc + k)), "scan_dsel");
         expect_at(k, K_SEG,  32'h40, "scan_seg");
      end
      expect_at(16, K_CUR, 32'h0, "m0_cursor");
      repeat (16) tick();

      // Cursor wrap and code wrap-down
      bus.mode = 1'b1;
      tick();
      expect_at(1, K_CUR, 32'h3, "left_wrap");
      pulse(B_L, 1'b0, 16'h0);
      expect_at(1, K_CUR, 32'h0, "right_wrap");
      pulse(B_R, 1'b0, 16'h0);
      expect_at(1, K_CUR, 32'h1, "right_inc");
      pulse(B_R, 1'b0, 16'h0);
      expect_at(1, K_CHARS, 32'h0090, "down_wrap");
      expect_at(1, K_CUR,   32'h1,    "down_cursor");
      pulse(B_D, 1'b0, 16'h0);

      // Blink of position 0 after an idle blink half-period
      p = cyc + 1;
      expect_at(1, K_CUR, 32'h0, "left_to0");
      for (int cc = p + 1; cc <= p + 32; cc++) begin
         if (idx_at(cc) == 1)
            v = 32'h10;
         else if (idx_at(cc) == 0 && cc >= p + 17)
            v = 32'h7F;
         else
            v = 32'h40;
         expect_at(cc - cyc, K_SEG, v, "blink_seg");
      end
      pulse(B_L, 1'b0, 16'h0);
      while (cyc < p + 32) tick();

      // Edit restarts the blink so the new code shows on the next slot
      expect_at(1, K_CHARS, 32'h0091, "up_pos0");
      c = cyc + 2;
      while (idx_at(c) != 0) c++;
      expect_at(c - cyc, K_SEG, 32'h79, "up_visible");
      pulse(B_U, 1'b0, 16'h0);
      while (cyc < c) tick();

      // Same-cycle combinations and code wrap at cursor 3
      expect_at(1, K_CUR, 32'h1, "to1");
      pulse(B_R, 1'b0, 16'h0);
      expect_at(1, K_CUR, 32'h2, "to2");
      pulse(B_R, 1'b0, 16'h0);
      expect_at(1, K_CHARS, 32'h0191, "up_right_chars");
      expect_at(1, K_CUR,   32'h3,    "up_right_cursor");
      pulse(B_U | B_R, 1'b0, 16'h0);
      expect_at(1, K_CUR, 32'h3, "lr_cancel");
      pulse(B_L | B_R, 1'b0, 16'h0);
      expect_at(1, K_CHARS, 32'h0191, "ud_cancel");
      pulse(B_U | B_D, 1'b0, 16'h0);
      expect_at(1, K_CHARS, 32'h9191, "down_wrap3");
      pulse(B_D, 1'b0, 16'h0);
      expect_at(1, K_CHARS, 32'h0191, "up_wrap3");
      pulse(B_U, 1'b0, 16'h0);

      // Load clamps out-of-range fields and beats a same-cycle up
      expect_at(1, K_CHARS, 32'h0590, "load_clamp");
      expect_at(1, K_CUR,   32'h3,    "load_cursor");
      pulse(B_U, 1'b1, 16'hC590);

      // Display-only mode ignores buttons but still loads
      bus.mode = 1'b0;
      expect_at(1, K_CUR, 32'h0, "m0_cur_hold");
      tick();
      expect_at(1, K_CHARS, 32'h0590, "m0_up_ignored");
      expect_at(1, K_CUR,   32'h0,    "m0_right_ignored");
      pulse(B_U | B_R, 1'b0, 16'h0);
      expect_at(1, K_CHARS, 32'h1234, "m0_load");
      pulse(4'b0, 1'b1, 16'h1234);
      expect_at(1, K_CHARS, 32'h2100, "load_edge");
      pulse(4'b0, 1'b1, 16'h21AF);

      // Asynchronous reset in the middle of an edit
      bus.mode = 1'b1;
      tick();
      expect_at(1, K_CHARS, 32'h7000, "load_7");
      pulse(4'b0, 1'b1, 16'h7000);
      expect_at(1, K_CUR, 32'h3, "cur3");
      pulse(B_L, 1'b0, 16'h0);
      tick();
      #2;
      rst        = 1'b1;
      bus.btn_up = 1'b1;
      expect_at(0, K_CHARS, 32'h0,  "arst_chars");
      expect_at(0, K_CUR,   32'h0,  "arst_cursor");
      expect_at(0, K_SEG,   32'h7F, "arst_seg");
      expect_at(0, K_DSEL,  32'hF,  "arst_dsel");
      tick();
      expect_at(0, K_CHARS, 32'h0, "arst_hold_chars");
      bus.btn_up = 1'b0;
      rst        = 1'b0;
      expect_at(1, K_CHARS, 32'h0001, "post_rst_up");
      pulse(B_U, 1'b0, 16'h0);

      // Drain the scoreboard with a bound
      guard = 0;
      while (rd < sbq.size() && guard < 100) begin
         tick();
         guard++;
      end
      n_left = sbq.size() - rd;
      if (n_left > 0)
         $display("FAIL drain: %0d expectations never checked, required 0", n_left);
      $display("%0d/%0d checks passed", n_pass, n_chk + n_left);
      $finish;
   end

endmodule

// File: doc/seg_editor.md
SEG_EDITOR -- requirements
Module: seg_editor

Interface
REQ-001 SHALL have parameter N_DIGITS, default 7: number of editable 7-seg positions, legal range 2..8.
REQ-002 SHALL have parameter N_CHARS, default 63: number of character codes per position, legal range 2..128.
REQ-003 SHALL have parameter SCAN_DIV, default 25000: clk cycles per digit scan slot.
REQ-004 SHALL have parameter BLINK_DIV, default 12500000: clk cycles per blink half-period.
REQ-005 SHALL define CW = $clog2(N_CHARS) and PW = $clog2(N_DIGITS) as derived localparams.
REQ-006 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port mode  input  1  1 = edit mode, 0 = display only.
REQ-009 SHALL have ports btn_left, btn_right, btn_up, btn_down  input  1 each  debounced single-cycle pulses.
REQ-010 SHALL have port load  input  1  single-cycle pulse, preset all positions.
REQ-011 SHALL have port load_data  input  N_DIGITS*CW  packed codes, position 0 in LSBs.
REQ-012 SHALL have port digit_sel  output  N_DIGITS  active-low one-hot scan enable; bit 0 = position 0.
REQ-013 SHALL have port seg  output  7  active-low segment pattern.
REQ-014 SHALL have port chars  output  N_DIGITS*CW  current codes, same packing as load_data.
REQ-015 SHALL have port cursor  output  PW  index of the position being edited.

Function
REQ-016 Scan counter SHALL count 0..SCAN_DIV-1 in both modes; at terminal count, scan index SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-017 digit_sel and seg SHALL be registered: one cycle after scan index changes, digit_sel = ~(1<<index) and seg = glyph(chars[index]).
REQ-018 Blink counter SHALL run 0..BLINK_DIV-1 only while mode=1; at terminal count it SHALL toggle blink_phase.
REQ-019 When mode=1, blink_phase=1 and index==cursor, seg SHALL be 7'h7F (blanked); digit_sel unaffected.
REQ-020 btn_left SHALL decrement cursor, wrapping 0 -> N_DIGITS-1; btn_right SHALL increment, wrapping N_DIGITS-1 -> 0.
REQ-021 btn_up SHALL increment chars[cursor], wrapping N_CHARS-1 -> 0; btn_down SHALL decrement, wrapping 0 -> N_CHARS-1.
REQ-022 left+right in the same cycle SHALL leave cursor unchanged; up+down in the same cycle SHALL leave codes unchanged.
REQ-023 A code change and a cursor move in the same cycle SHALL apply the change at the pre-move cursor.
REQ-024 Any accepted edit pulse (left/right/up/down) SHALL clear the blink counter and blink_phase, so the edited digit is immediately visible.
REQ-025 load SHALL be accepted in either mode, has priority over up/down, and SHALL write all positions in one cycle; any load_data field >= N_CHARS SHALL be written as 0.
REQ-026 With mode=0, btn_* SHALL be ignored, cursor SHALL be held at 0, and the blink counter and blink_phase SHALL be held at 0.
REQ-027 chars and cursor outputs SHALL update on the clock edge following the accepting pulse (latency 1).

Reset
REQ-028 On rst: chars all 0, cursor 0, scan index 0, scan and blink counters 0, blink_phase 0, digit_sel all ones, seg 7'h7F.
REQ-029 Reset asserted mid-scan or mid-edit SHALL take effect immediately (asynchronous), discarding any same-cycle pulse.

Structure
REQ-030 A shared package SHALL hold SEG_BLANK = 7'h7F and the default parameter values.
REQ-031 The code-to-pattern lookup SHALL be one combinational sub-module, seg_glyph (CW-bit code in, 7-bit active-low pattern out, unmapped codes -> SEG_BLANK).

Verification (N_DIGITS=4, N_CHARS=10, SCAN_DIV=4, BLINK_DIV=16)
REQ-032 Reset, mode=0 -> digit_sel cycles 1110,1101,1011,0111 every 4 clk; seg = glyph(0); cursor=0.
REQ-033 mode=1, btn_left once -> cursor=3; btn_right twice -> cursor=1; btn_down once -> chars[1]=9.
REQ-034 mode=1, idle 16 clk -> position 0 blanked (seg=7F) when scanned; btn_up -> chars[0]=1, visible next scan slot.
REQ-035 Same-cycle btn_up+btn_right at cursor 2 -> chars[2] incremented, cursor=3; same-cycle left+right -> cursor unchanged.
REQ-036 load with fields {12,5,9,0} (position 3..0) -> chars = {0,5,9,0}; mode=0 with btn_up -> no change.
REQ-037 rst asserted mid-edit at cursor 3 with code 7 -> immediately chars all 0, cursor 0, seg=7F, digit_sel=1111.
